// File: rtl/uart_rx_sampler.sv
// Mid-bit-sampling UART receiver feeding the receive FIFO write port.
// It checks the start, parity and stop bits and reports frame, parity and overrun errors as one-cycle pulses.
module uart_rx_sampler #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int PARITY       = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  input  logic       wrfull,
  output logic [7:0] rf_data,
  output logic       fr_wrreq,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic ODD_PAR = (PARITY == 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HIGH} state_t;

  state_t           state;
  logic             rx_meta, rx_s, rx_d;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             perr;

  // The line idles high, so the synchronizer resets to 1 to avoid a false start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= uart_rxd;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      perr       <= 1'b0;
      rf_data    <= '0;
      fr_wrreq   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      fr_wrreq   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_d && !rx_s) begin
            cnt   <= '0;
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            if (!rx_s) begin
              state   <= DATA;
              cnt     <= '0;
              bit_idx <= '0;
              perr    <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= (PARITY != 0) ? PAR : STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PAR: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            perr  <= ((^shreg) ^ rx_s) != ODD_PAR;
            state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // Leaving at mid-stop bit gives a back-to-back frame's start edge time to be seen.
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
              if (perr) begin
                parity_err <= 1'b1;
              end else if (wrfull) begin
                overrun <= 1'b1;
              end else begin
                rf_data  <= shreg;
                fr_wrreq <= 1'b1;
              end
            end else begin
              frame_err  <= 1'b1;
              parity_err <= perr;
              state      <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler at 16 clocks per bit.
// One instance runs without parity and a second runs with even parity.
module tb_uart_rx_sampler;

  localparam int N = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd0 = 1'b1, rxd2 = 1'b1;
  logic       wrfull0 = 1'b0, wrfull2 = 1'b0;
  logic [7:0] rf_data0, rf_data2;
  logic       fr_wrreq0, frame_err0, parity_err0, overrun0, busy0;
  logic       fr_wrreq2, frame_err2, parity_err2, overrun2, busy2;

  int vectors = 0, miscompares = 0;
  int cyc = 0, start_cyc = 0;
  int wr0 = 0, ferr0 = 0, perr0 = 0, ovr0 = 0, busy_cnt0 = 0, wr_cyc0 = 0;
  int wr2 = 0, ferr2 = 0, perr2 = 0, ovr2 = 0, both2 = 0, wr_cyc2 = 0;
  logic [7:0] last_data0 = 8'h00, prev_data0 = 8'h00;

  uart_rx_sampler #(.CLKS_PER_BIT(N), .PARITY(0)) dut0 (
    .clk(clk), .rst(rst), .uart_rxd(rxd0), .wrfull(wrfull0),
    .rf_data(rf_data0), .fr_wrreq(fr_wrreq0), .frame_err(frame_err0),
    .parity_err(parity_err0), .overrun(overrun0), .busy(busy0)
  );

  uart_rx_sampler #(.CLKS_PER_BIT(N), .PARITY(2)) dut2 (
    .clk(clk), .rst(rst), .uart_rxd(rxd2), .wrfull(wrfull2),
    .rf_data(rf_data2), .fr_wrreq(fr_wrreq2), .frame_err(frame_err2),
    .parity_err(parity_err2), .overrun(overrun2), .busy(busy2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters sample on the falling edge so each high cycle is counted exactly once.
  always @(negedge clk) begin
    if (!rst) begin
      if (fr_wrreq0) begin
        wr0        <= wr0 + 1;
        wr_cyc0    <= cyc;
        prev_data0 <= last_data0;
        last_data0 <= rf_data0;
      end
      if (frame_err0)  ferr0 <= ferr0 + 1;
      if (parity_err0) perr0 <= perr0 + 1;
      if (overrun0)    ovr0  <= ovr0 + 1;
      if (busy0)       busy_cnt0 <= busy_cnt0 + 1;
      if (fr_wrreq2) begin
        wr2     <= wr2 + 1;
        wr_cyc2 <= cyc;
      end
      if (frame_err2)  ferr2 <= ferr2 + 1;
      if (parity_err2) perr2 <= perr2 + 1;
      if (overrun2)    ovr2  <= ovr2 + 1;
      if (frame_err2 && parity_err2) both2 <= both2 + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic setLine(input bit sel, input logic v);
    if (sel) rxd2 = v;
    else     rxd0 = v;
  endtask

  task automatic holdBit(input bit sel, input logic v);
    @(negedge clk);
    setLine(sel, v);
    repeat (N - 1) @(negedge clk);
  endtask

  task automatic applyStimulus(input bit sel, input logic [7:0] data, input bit has_par,
                               input bit par_bit, input bit stop_bit);
    @(negedge clk);
    setLine(sel, 1'b0);
    start_cyc = cyc + 1;
    repeat (N - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) holdBit(sel, data[i]);
    if (has_par) holdBit(sel, par_bit);
    holdBit(sel, stop_bit);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int b0;
    waitCycles(3);
    checkOutput("reset rf_data0", rf_data0, 8'h00);
    checkOutput("reset fr_wrreq0", fr_wrreq0, 1'b0);
    checkOutput("reset busy0", busy0, 1'b0);
    checkOutput("reset err0", {frame_err0, parity_err0, overrun0}, 3'b000);
    checkOutput("reset rf_data2", rf_data2, 8'h00);
    checkOutput("reset busy2", busy2, 1'b0);
    rst = 1'b0;
    waitCycles(5);

    applyStimulus(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
    waitCycles(10);
    checkOutput("byte55 writes", wr0, 1);
    checkOutput("byte55 data", rf_data0, 8'h55);
    checkOutput("byte55 strobe time", wr_cyc0, start_cyc + 154);
    checkOutput("byte55 busy cycles", busy_cnt0, 152);
    checkOutput("byte55 errors", ferr0 + perr0 + ovr0, 0);

    applyStimulus(1'b0, 8'hA3, 1'b0, 1'b0, 1'b1);
    waitCycles(10);
    checkOutput("byteA3 writes", wr0, 2);
    checkOutput("byteA3 data", rf_data0, 8'hA3);
    checkOutput("byteA3 errors", ferr0 + perr0 + ovr0, 0);

    b0 = busy_cnt0;
    @(negedge clk) rxd0 = 1'b0;
    repeat (4) @(negedge clk);
    rxd0 = 1'b1;
    waitCycles(30);
    checkOutput("glitch busy cycles", busy_cnt0 - b0, 8);
    checkOutput("glitch writes", wr0, 2);
    checkOutput("glitch errors", ferr0 + perr0 + ovr0, 0);

    applyStimulus(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    waitCycles(40 * N);
    rxd0 = 1'b1;
    waitCycles(20);
    checkOutput("break frame_err", ferr0, 1);
    checkOutput("break writes", wr0, 2);
    checkOutput("break rf_data", rf_data0, 8'hA3);
    checkOutput("break parity_err", perr0, 0);
    applyStimulus(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    waitCycles(10);
    checkOutput("after break writes", wr0, 3);
    checkOutput("after break data", rf_data0, 8'h11);
    checkOutput("after break frame_err", ferr0, 1);

    wrfull0 = 1'b1;
    applyStimulus(1'b0, 8'h7E, 1'b0, 1'b0, 1'b1);
    waitCycles(10);
    wrfull0 = 1'b0;
    checkOutput("overrun pulses", ovr0, 1);
    checkOutput("overrun writes", wr0, 3);
    checkOutput("overrun rf_data", rf_data0, 8'h11);

    applyStimulus(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    waitCycles(10);
    checkOutput("parity ok writes", wr2, 1);
    checkOutput("parity ok data", rf_data2, 8'h07);
    checkOutput("parity ok perr", perr2, 0);
    checkOutput("parity strobe time", wr_cyc2, start_cyc + 170);
    applyStimulus(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    waitCycles(10);
    checkOutput("parity bad perr", perr2, 1);
    checkOutput("parity bad writes", wr2, 1);
    checkOutput("parity bad ferr", ferr2, 0);
    applyStimulus(1'b1, 8'h07, 1'b1, 1'b0, 1'b0);
    holdBit(1'b1, 1'b1);
    waitCycles(10);
    checkOutput("both errs ferr", ferr2, 1);
    checkOutput("both errs perr", perr2, 2);
    checkOutput("both errs same cycle", both2, 1);
    checkOutput("both errs writes", wr2, 1);
    checkOutput("parity overrun", ovr2, 0);

    applyStimulus(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1);
    waitCycles(10);
    checkOutput("b2b writes", wr0, 5);
    checkOutput("b2b first", prev_data0, 8'h5A);
    checkOutput("b2b second", last_data0, 8'hC3);

    fork
      applyStimulus(1'b0, 8'hF0, 1'b0, 1'b0, 1'b1);
      begin
        waitCycles(85);
        rst = 1'b1;
        waitCycles(3);
        checkOutput("midrst rf_data", rf_data0, 8'h00);
        checkOutput("midrst busy", busy0, 1'b0);
        checkOutput("midrst fr_wrreq", fr_wrreq0, 1'b0);
        rst = 1'b0;
      end
    join
    waitCycles(20);
    checkOutput("midrst writes", wr0, 5);
    checkOutput("midrst ferr", ferr0, 1);
    checkOutput("midrst rf held", rf_data0, 8'h00);
    applyStimulus(1'b0, 8'h42, 1'b0, 1'b0, 1'b1);
    waitCycles(10);
    checkOutput("post rst writes", wr0, 6);
    checkOutput("post rst data", rf_data0, 8'h42);
    checkOutput("post rst overrun", ovr0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

Mid-bit-sampling UART receiver. It deserialises the asynchronous `uart_rxd` line into bytes and pushes each good byte into the receive FIFO write port (`rf_data`/`fr_wrreq`, respecting `wrfull`). It is the stage directly upstream of `rec_fifo` on the receive path. It also validates start, parity and stop bits and reports framing, parity and overrun errors as single-cycle pulses.

## Interface
- `CLKS_PER_BIT`, default 5208: `clk` cycles per bit (50 MHz / 9600). Legal range is 8 or more; an odd value is allowed.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `clk`  in  1  system clock, single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `uart_rxd`  in  1  serial input, asynchronous, idle high.
- `wrfull`  in  1  receive FIFO full flag.
- `rf_data`  out  8  received byte; holds its value until the next write.
- `fr_wrreq`  out  1  one-cycle FIFO write strobe.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `parity_err`  out  1  one-cycle pulse: parity mismatch.
- `overrun`  out  1  one-cycle pulse: good byte dropped because `wrfull` = 1.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- **Input sync**
  - `uart_rxd` passes through a 2-FF synchronizer (both flops reset to 1), giving `rx_s`.
  - A registered copy `rx_d` provides edge detection.
- **FSM states:** IDLE, START, DATA, PAR, STOP, WAIT_HIGH.
- **IDLE:** a falling edge (`rx_d`=1, `rx_s`=0) loads bit counter `cnt` with 0 and moves to START.
- **START:** at `cnt` = H-1, where H = CLKS_PER_BIT/2 (floor), sample `rx_s`.
  - 0: move to DATA, clear `cnt`, clear bit index.
  - 1: glitch; return to IDLE silently, no pulse.
- **DATA:** at each `cnt` = CLKS_PER_BIT-1, sample `rx_s` and shift it into bit 7 of the shift register.
  - Bits arrive LSB first.
  - After 8 samples, go to PAR if PARITY ≠ 0, otherwise to STOP.
- **PAR:** sample one bit at `cnt` = CLKS_PER_BIT-1.
  - Mismatch is latched internally as `perr`.
  - Odd parity: data bits plus parity bit contain an odd number of 1s. Even parity: an even number.
- **STOP:** sample at `cnt` = CLKS_PER_BIT-1. Outcome on the next cycle:
  - Stop = 1, no `perr`, `wrfull` = 0: load `rf_data` and pulse `fr_wrreq`.
  - Stop = 1, no `perr`, `wrfull` = 1: pulse `overrun`; no write; `rf_data` unchanged.
  - Stop = 1, `perr`: pulse `parity_err`; no write.
  - Stop = 0: pulse `frame_err`; no write. If `perr` is also set, pulse `parity_err` in the same cycle.
- **Exit from STOP:** go to IDLE on a good stop bit, or to WAIT_HIGH on a bad one.
  - Exiting at mid-stop bit lets a back-to-back frame's start edge be caught.
- **WAIT_HIGH:** stay until `rx_s` = 1, then go to IDLE. This means a break (held-low line) produces exactly one `frame_err` and no false starts.
- `wrfull` is sampled only in the cycle the stop sample is taken.
- Counter width is $clog2(CLKS_PER_BIT).

## Timing
- **Reset values:** `rf_data` = 0, `fr_wrreq` = 0, all error pulses 0, `busy` = 0, FSM = IDLE, synchronizer flops = 1.
- **Reference point:** E is the edge-detect cycle in IDLE; N is CLKS_PER_BIT.
- **Sample times relative to E:**
  - Start sample: E+H.
  - Data bit k (k = 0..7): E+H+(k+1)·N.
  - Parity bit: E+H+9N.
  - Stop bit: E+H+9N, or E+H+10N when parity is enabled.
- **Outputs:** `fr_wrreq` and the error pulses are high for exactly one cycle, at stop sample + 1. `rf_data` is valid in the same cycle as `fr_wrreq` and is held afterwards.
- **Input latency:** `uart_rxd` to `rx_s` is 2 cycles; E is one cycle after `rx_s` falls.
- **Reset mid-frame:** all outputs return to reset values immediately; the partial byte is discarded and no pulse is emitted.
- `busy` rises at E+1 and falls in the cycle after leaving STOP or WAIT_HIGH.

## Test plan
Benches use CLKS_PER_BIT = 16. Each bit is driven for 16 cycles.
- **Basic byte:** send 0x55, then 0xA3, no parity → `fr_wrreq` pulses once per byte, at E+8+144+1; `rf_data` = 0x55 then 0xA3; no error pulses.
- **Glitch rejection:** drive `uart_rxd` low for 4 cycles, then high → `busy` pulses briefly; no `fr_wrreq`; no errors.
- **Framing error / break:**
  - Send 0x3C with stop = 0 → one `frame_err`, no write.
  - Then hold the line low for 40 bit times → no further pulses; the next valid 0x11 is received.
- **Overrun:** `wrfull` = 1 while sending 0x7E → one `overrun`, no `fr_wrreq`, `rf_data` still holds the previous value.
- **Parity (PARITY = 2):**
  - 0x07 with parity bit 1 → written.
  - 0x07 with parity bit 0 → one `parity_err`, no write.
- **Back-to-back and reset:** two frames with zero idle gap → both bytes written. Assert `rst` during bit 4 of a third frame → outputs zero, no write; the next frame is received correctly.
